// File: rtl/telemetry_fifo_arbiter_pkg.sv
// Purpose: shared types and widths for the telemetry fifo write-side arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package telem_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Widths shared with the fifo instance and the UART reader that demuxes on id.
   localparam int TELEM_NREQ      = 3;
   localparam int TELEM_ID_W      = 2;
   localparam int TELEM_PAYLOAD_W = 14;
   localparam int TELEM_DWIDTH    = TELEM_ID_W + TELEM_PAYLOAD_W;
   localparam int TELEM_MAX_BEATS = 8;
   localparam int TELEM_IDLE_TMO  = 15;

   // Saturating 16-bit increment used by the stall counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/telemetry_fifo_arbiter_if.sv
// Purpose: producer request bundle plus fifo write port for the telemetry arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per producer, fifo_full from the fifo.
interface telemetry_fifo_arbiter_if
   import telem_pkg::*;
#(
   parameter int NREQ      = TELEM_NREQ,
   parameter int ID_W      = TELEM_ID_W,
   parameter int PAYLOAD_W = TELEM_PAYLOAD_W
);
   logic [NREQ-1:0]                 req_valid;
   logic [NREQ-1:0]                 req_last;
   logic [NREQ-1:0][PAYLOAD_W-1:0]  req_data;
   logic [NREQ-1:0]                 req_ready;
   logic                            fifo_full;
   logic                            fifo_wr_en;
   logic [ID_W+PAYLOAD_W-1:0]       fifo_din;
   logic [ID_W-1:0]                 gnt_id;
   logic                            pkt_err;
   logic [15:0]                     full_cycles;

   // Arbiter side.
   modport master (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_din, gnt_id, pkt_err, full_cycles
   );

   // Producers / fifo side.
   modport slave (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din, gnt_id, pkt_err, full_cycles
   );
endinterface

// File: rtl/telemetry_fifo_arbiter_rr_pick.sv
// Purpose: round-robin picker, first requester after the last grant (mod NREQ).
// Latency: combinational.
// Backpressure: none; pure function of req and last.
module telemetry_fifo_arbiter_rr_pick #(
   parameter int NREQ  = 3,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] win,
   output logic             any
);
   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      win  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = IDX_W'((int'(last) + i) % NREQ);
         if (req[cand]) begin
            win = cand;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/telemetry_fifo_arbiter.sv
// Purpose: packet-granular round-robin sharing of the telemetry fifo write port.
// Latency: 1 ARB cycle per packet, then beats pass combinationally to the fifo.
// Backpressure: fifo_full stalls the locked producer; non-granted producers see ready=0.
module telemetry_fifo_arbiter
   import telem_pkg::*;
#(
   parameter int NREQ      = TELEM_NREQ,
   parameter int ID_W      = TELEM_ID_W,
   parameter int PAYLOAD_W = TELEM_PAYLOAD_W,
   parameter int MAX_BEATS = TELEM_MAX_BEATS,
   parameter int IDLE_TMO  = TELEM_IDLE_TMO
) (
   input  logic                    clk,
   input  logic                    rst,
   telemetry_fifo_arbiter_if.master bus
);
   localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int IDLE_W = $clog2(IDLE_TMO + 1);

   arb_state_e               state_q, state_d;
   logic [ID_W-1:0]          last_grant_q, last_grant_d;
   logic [ID_W-1:0]          gnt_id_q, gnt_id_d;
   logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
   logic [15:0]              full_cycles_q, full_cycles_d;

   logic [NREQ-1:0]          req_ready;
   logic                     fifo_wr_en;
   logic [ID_W+PAYLOAD_W-1:0] fifo_din;
   logic                     pkt_err;
   logic [ID_W-1:0]          pick_win;
   logic                     pick_any;

   telemetry_fifo_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req  (bus.req_valid),
      .last (last_grant_q),
      .win  (pick_win),
      .any  (pick_any)
   );

   // State and counter registers; reset abandons any lock immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ARB;
         last_grant_q  <= ID_W'(NREQ - 1);
         gnt_id_q      <= '0;
         beat_cnt_q    <= '0;
         idle_cnt_q    <= '0;
         full_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         gnt_id_q      <= gnt_id_d;
         beat_cnt_q    <= beat_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         full_cycles_q <= full_cycles_d;
      end
   end

   // Next-state, counters and the fifo/ready muxing for the locked producer.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      gnt_id_d      = gnt_id_q;
      beat_cnt_d    = beat_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      full_cycles_d = full_cycles_q;
      req_ready     = '0;
      fifo_wr_en    = 1'b0;
      fifo_din      = '0;
      pkt_err       = 1'b0;

      case (state_q)
         ARB: begin
            beat_cnt_d = '0;
            idle_cnt_d = '0;
            if (pick_any) begin
               gnt_id_d = pick_win;
               state_d  = LOCK;
            end
         end
         LOCK: begin
            fifo_din = {gnt_id_q, bus.req_data[gnt_id_q]};
            if (bus.req_valid[gnt_id_q]) begin
               if (bus.fifo_full) begin
                  // Stall: counters frozen, only the stall counter moves.
                  full_cycles_d = sat_inc16(full_cycles_q);
               end else begin
                  req_ready[gnt_id_q] = 1'b1;
                  fifo_wr_en          = 1'b1;
                  idle_cnt_d          = '0;
                  if (bus.req_last[gnt_id_q] ||
                      beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
                     pkt_err      = !bus.req_last[gnt_id_q];
                     state_d      = ARB;
                     last_grant_d = gnt_id_q;
                     beat_cnt_d   = '0;
                  end else begin
                     beat_cnt_d = beat_cnt_q + 1'b1;
                  end
               end
            end else if (idle_cnt_q == IDLE_W'(IDLE_TMO)) begin
               // Producer stalled too long mid-packet: drop the lock.
               pkt_err      = 1'b1;
               state_d      = ARB;
               last_grant_d = gnt_id_q;
               beat_cnt_d   = '0;
               idle_cnt_d   = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   assign bus.req_ready   = req_ready;
   assign bus.fifo_wr_en  = fifo_wr_en;
   assign bus.fifo_din    = fifo_din;
   assign bus.gnt_id      = gnt_id_q;
   assign bus.pkt_err     = pkt_err;
   assign bus.full_cycles = full_cycles_q;
endmodule
